// File: rtl/dice_roll_controller.sv
// Dice roll controller: debounced button -> tumbling roll pulses -> 7-segment display.
// Define DICE_SLOWDOWN_EN for a decelerating tumble (step k lasts (k+1)*STEP_CYCLES).
module dice_roll_controller #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STEP_CYCLES     = 2500000,
    parameter int TUMBLE_STEPS    = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_raw,
    input  logic [3:0] dice_value,
    output logic       roll,
    output logic [6:0] seg,
    output logic       busy,
    output logic       result_valid,
    output logic [3:0] result
);

`ifdef DICE_SLOWDOWN_EN
    localparam int TMAX = TUMBLE_STEPS * STEP_CYCLES;
`else
    localparam int TMAX = STEP_CYCLES;
`endif
    localparam int TW = $clog2(TMAX + 1);
    localparam int SW = $clog2(TUMBLE_STEPS + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TUMBLE = 2'd1,
        SHOW   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic            press_q, press_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   step_q, step_d;
    logic [3:0]      val_q, val_d;
    logic [3:0]      result_q, result_d;
    logic [6:0]      seg_q, seg_d;
    logic            roll_q, roll_d;
    logic            busy_q, busy_d;
    logic            rv_q, rv_d;
    logic            step_end, last_step, enter;

    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        case (v)
            4'd1:    seg_enc = 7'b0000110;
            4'd2:    seg_enc = 7'b1011011;
            4'd3:    seg_enc = 7'b1001111;
            4'd4:    seg_enc = 7'b1100110;
            4'd5:    seg_enc = 7'b1101101;
            4'd6:    seg_enc = 7'b1111101;
            default: seg_enc = 7'b1000000;
        endcase
    endfunction

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        deb_d   = deb_q;
        dcnt_d  = '0;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

`ifdef DICE_SLOWDOWN_EN
    logic [TW-1:0] lim_q, lim_d;

    assign step_end = (timer_q == lim_q);

    always_comb begin
        lim_d = lim_q;
        if (enter) begin
            lim_d = TW'(STEP_CYCLES - 1);
        end else if (state_q == TUMBLE && step_end) begin
            lim_d = lim_q + TW'(STEP_CYCLES);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lim_q <= '0;
        end else begin
            lim_q <= lim_d;
        end
    end
`else
    assign step_end = (timer_q == TW'(STEP_CYCLES - 1));
`endif

    assign last_step = (step_q == SW'(TUMBLE_STEPS - 1));
    assign enter     = (state_q != TUMBLE) && (state_d == TUMBLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, SHOW: if (press_q) state_d = TUMBLE;
            TUMBLE:     if (step_end && last_step) state_d = SHOW;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d  = timer_q;
        step_d   = step_q;
        val_d    = val_q;
        seg_d    = seg_q;
        result_d = result_q;
        roll_d   = 1'b0;
        busy_d   = busy_q;
        rv_d     = rv_q;
        if (enter) begin
            timer_d = '0;
            step_d  = '0;
            busy_d  = 1'b1;
            rv_d    = 1'b0;
            roll_d  = 1'b1;
        end else if (state_q == TUMBLE) begin
            // dice_value has settled one cycle after the roll pulse.
            if (timer_q == TW'(1)) begin
                val_d = dice_value;
                seg_d = seg_enc(dice_value);
            end
            if (step_end) begin
                timer_d = '0;
                step_d  = step_q + SW'(1);
                if (state_d == SHOW) begin
                    busy_d   = 1'b0;
                    rv_d     = 1'b1;
                    result_d = val_d;
                end else begin
                    roll_d = 1'b1;
                end
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            deb_q    <= 1'b0;
            dcnt_q   <= '0;
            press_q  <= 1'b0;
            timer_q  <= '0;
            step_q   <= '0;
            val_q    <= '0;
            seg_q    <= '0;
            result_q <= '0;
            roll_q   <= 1'b0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            press_q  <= press_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            val_q    <= val_d;
            seg_q    <= seg_d;
            result_q <= result_d;
            roll_q   <= roll_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
        end
    end

    assign roll         = roll_q;
    assign seg          = seg_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result       = result_q;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Scoreboard bench for dice_roll_controller: randomized dice values, timing
// and display checked against a behavioural model of the roll sequence.
module tb_dice_roll_controller;

    localparam int DEB = 4;
    localparam int STEP = 8;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_raw;
    logic [3:0] dice_value = 4'd0;
    logic       roll;
    logic [6:0] seg;
    logic       busy;
    logic       result_valid;
    logic [3:0] result;

    dice_roll_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_CYCLES(STEP),
        .TUMBLE_STEPS(N)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .dice_value(dice_value),
        .roll(roll),
        .seg(seg),
        .busy(busy),
        .result_valid(result_valid),
        .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring-buffer queues: written by stimulus, drained by dice model / monitor.
    logic [3:0] feed[256];
    int         feed_wp = 0, feed_rp = 0;
    logic [6:0] eseg[256];
    int         eseg_wp = 0, eseg_rp = 0;
    logic [3:0] eres[256];
    int         eres_wp = 0, eres_rp = 0;
    int         est[256];
    int         est_wp = 0, est_rp = 0;
    int         tmo_cnt = 0;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [6:0] enc_ref(input logic [3:0] v);
        case (v)
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic int roll_off(input int k);
`ifdef DICE_SLOWDOWN_EN
        return STEP * k * (k + 1) / 2;
`else
        return STEP * k;
`endif
    endfunction

    // Dice model: new value appears on the edge that samples roll high.
    always @(posedge clk) begin
        if (!reset_n) begin
            feed_rp <= feed_wp;
        end else if (roll) begin
            if (feed_rp != feed_wp) begin
                dice_value <= feed[feed_rp % 256];
                feed_rp    <= feed_rp + 1;
            end else begin
                dice_value <= 4'd0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        logic busy_p, rv_p, in_rst;
        int   t0, k, seg_due, tmo_seen;
        busy_p = 0; rv_p = 0; in_rst = 0;
        t0 = 0; k = 0; seg_due = -1; tmo_seen = 0;
        forever begin
            @(negedge clk);
            if (tmo_cnt != tmo_seen) begin
                chk("wait_timeout", tmo_cnt, tmo_seen);
                tmo_seen = tmo_cnt;
            end
            if (!reset_n) begin
                if (!in_rst) begin
                    chk("rst_roll", int'(roll), 0);
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_valid", int'(result_valid), 0);
                    chk("rst_seg", int'(seg), 0);
                    chk("rst_result", int'(result), 0);
                end
                in_rst  = 1;
                eseg_rp = eseg_wp;
                eres_rp = eres_wp;
                est_rp  = est_wp;
                busy_p  = 0;
                rv_p    = 0;
                k       = 0;
                seg_due = -1;
            end else begin
                in_rst = 0;
                if (busy && !busy_p) begin
                    t0 = cyc;
                    k  = 0;
                    if (est_rp == est_wp) begin
                        chk("unexpected_tumble", cyc, -1);
                    end else begin
                        chk("tumble_start", cyc, est[est_rp % 256]);
                        est_rp++;
                    end
                    chk("valid_drop", int'(result_valid), 0);
                end
                if (roll) begin
                    if (!busy || k >= N) begin
                        chk("extra_roll", k, -1);
                    end else begin
                        chk("roll_offset", cyc - t0, roll_off(k));
                        k++;
                        seg_due = cyc + 2;
                    end
                end
                if (cyc == seg_due) begin
                    if (eseg_rp == eseg_wp) begin
                        chk("seg_no_expect", int'(seg), -1);
                    end else begin
                        chk("tumble_seg", int'(seg), int'(eseg[eseg_rp % 256]));
                        eseg_rp++;
                    end
                    seg_due = -1;
                end
                if (result_valid && !rv_p) begin
                    chk("tumble_len", cyc - t0, roll_off(N));
                    chk("roll_count", k, N);
                    chk("busy_at_show", int'(busy), 0);
                    if (eres_rp == eres_wp) begin
                        chk("result_no_expect", int'(result), -1);
                    end else begin
                        chk("result", int'(result), int'(eres[eres_rp % 256]));
                        chk("show_seg", int'(seg),
                            int'(enc_ref(eres[eres_rp % 256])));
                        eres_rp++;
                    end
                end
                busy_p = busy;
                rv_p   = result_valid;
            end
        end
    end

    task automatic press_ok(input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2);
        logic [3:0] vs[3];
        vs[0] = v0; vs[1] = v1; vs[2] = v2;
        for (int i = 0; i < N; i++) begin
            feed[feed_wp % 256] = vs[i];
            feed_wp++;
            eseg[eseg_wp % 256] = enc_ref(vs[i]);
            eseg_wp++;
        end
        eres[eres_wp % 256] = vs[N-1];
        eres_wp++;
        @(posedge clk);
        #1;
        btn_raw = 1'b1;
        est[est_wp % 256] = cyc + DEB + 3;
        est_wp++;
        repeat (8) @(posedge clk);
        #1 btn_raw = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic press_ignored();
        @(posedge clk);
        #1 btn_raw = 1'b1;
        repeat (8) @(posedge clk);
        #1 btn_raw = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_show();
        int n;
        n = 0;
        while (!(result_valid && !busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) tmo_cnt++;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        btn_raw = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Bouncing button: never stable long enough to register.
        for (int i = 0; i < 10; i++) begin
            #1 btn_raw = ~btn_raw;
            repeat (2) @(posedge clk);
        end
        #1 btn_raw = 1'b0;
        repeat (12) @(posedge clk);

        press_ok(4'd3, 4'd7, 4'd5);
        wait_show();

        // Press mid-tumble is dropped; the tumble still has three rolls.
        press_ok(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(1, 6)));
        press_ignored();
        wait_show();

        // Restart from SHOW, including a zero value on the final roll.
        press_ok(4'd6, 4'd2, 4'd0);
        wait_show();
        for (int i = 0; i < 6; i++) begin
            press_ok(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            wait_show();
        end

        // Reset mid-tumble, then idle with no press.
        press_ok(4'd1, 4'd2, 4'd3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (40) @(posedge clk);

        press_ok(4'd4, 4'd9, 4'd2);
        wait_show();
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
